// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   state_e   - controller state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width - width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // One extra bit over clog2 so the counter can represent WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
//   start, sub, a, b        - request (driven by master)
//   busy, done, sum, cout,  - status and registered result (driven by slave)
//   ovf
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/fulladdder.sv
// fulladdder: 1-bit full adder cell.
//   In1, In2, Cin - addend bits and carry in
//   Sum, Cout     - sum bit and carry out
module fulladdder (
  input  logic In1,
  input  logic In2,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = In1 ^ In2 ^ Cin;
  assign Cout = (In1 & In2) | (Cin & (In1 ^ In2));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first, one bit per clock.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - serial_adder_if slave: start/sub/a/b in; busy/done/sum/cout/ovf out
// Subtraction is a + ~b + 1 (carry seeded with sub). done is registered, so it
// appears in the IDLE cycle right after DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Partial result; holds the lower WIDTH-1 bits, the MSB comes straight from the cell.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic fa_sum;
  logic fa_cout;

  fulladdder u_fa (
    .In1  (a_q[0]),
    .In2  (b_q[0]),
    .Cin  (c_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = (state_q == StDone);

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        acc_d            = acc_q >> 1;
        acc_d[WIDTH-2]   = fa_sum;
        c_d              = fa_cout;
        cnt_d            = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          sum_d   = {fa_sum, acc_q};
          cout_d  = fa_cout;
          // c_q is the carry into the MSB during the last bit.
          ovf_d   = c_q ^ fa_cout;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while the state is RUN.
REQ-009 done  output  1  one-cycle pulse; result valid and updated.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-012 ovf  output  1  two's-complement overflow of the last operation.

Function
REQ-013 Processing SHALL be bit-serial, LSB first, one bit per clk through a single 1-bit full-adder cell.
REQ-014 States SHALL be IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after WIDTH bit-cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-015 On the IDLE start edge the block SHALL load A, load B (inverted when sub=1), set the carry register to sub, and clear the bit counter.
REQ-016 Each RUN cycle SHALL shift both operand registers right by one, shift the full-adder sum bit into the result MSB, store the full-adder carry, and increment the counter.
REQ-017 The counter SHALL be clog2(WIDTH)+1 bits wide. RUN SHALL exit when the counter reaches WIDTH-1 in a RUN cycle.
REQ-018 Latency: with start sampled at edge N, done SHALL be high during the cycle following edge N+WIDTH+1, i.e. WIDTH+2 edges from request to done visible.
REQ-019 sum, cout and ovf SHALL update only on the RUN->DONE edge and hold until the next RUN->DONE edge.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 Arithmetic is modulo 2^WIDTH. No saturation.
REQ-022 start while busy or in DONE SHALL be ignored and not queued. sub, a and b SHALL be don't-care outside the IDLE start edge.
REQ-023 Back-to-back operation: start held high SHALL begin a new operation on the first IDLE cycle after DONE.

Reset
REQ-024 rst_n=0 at a clk edge SHALL force IDLE and clear busy, done, sum, cout, ovf, operand, carry and counter registers to 0.
REQ-025 Reset during RUN SHALL abort the operation. No done pulse and no output update SHALL follow.
REQ-026 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-027 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared package, serial_adder_pkg.
REQ-028 The bit cell SHALL be the team's existing 1-bit full adder, fulladdder (ports In1, In2, Cin, Sum, Cout), instantiated exactly once. All other logic SHALL be in serial_adder.

Verification
REQ-029 Each scenario below uses WIDTH=8. Each scenario SHALL check the done pulse width (1 cycle) and the latency given in REQ-018.
REQ-030 add a=8'h35, b=8'h4A -> sum=8'h7F, cout=0, ovf=0.
REQ-031 add 8'hFF+8'h01 -> sum=8'h00, cout=1, ovf=0; then add 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-032 sub 8'h05-8'h07 -> sum=8'hFE, cout=0, ovf=0; then sub 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
REQ-033 Start pulse on the 3rd RUN cycle with different operands -> ignored; first result unchanged; exactly one done.
REQ-034 rst_n=0 on the 4th RUN cycle -> busy=0 next cycle, no done, and sum/cout/ovf=0. A following add 8'h01+8'h01 -> sum=8'h02.
REQ-035 start held high for 3 operations -> three done pulses exactly WIDTH+2 cycles apart.
